// File: rtl/cla_serial_add_ctrl.sv
// ============================================================================
// Module   : cla_serial_add_ctrl (with helper cla4_slice)
// Purpose  : WIDTH-bit adder built from one 4-bit CLA slice, one nibble per clock.
//            Optional subtract/overflow ports are enabled with CLA_SERIAL_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s = w_p ^ w_c;
endmodule

module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] c_last = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_last;
    logic              w_run;

    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_sum_sh;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [WIDTH-1:0]  w_b_in;
    logic              w_c_in;
    logic [3:0]        w_s;
    logic              w_co;

`ifdef CLA_SERIAL_SUB_EN
    logic              r_ovf;
    logic              w_c3;

    // Subtraction is a + ~b + 1; the carry-in port is overridden.
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
    // Carry into the MSB recovered from the slice's top sum bit.
    assign w_c3   = r_a_sh[3] ^ r_b_sh[3] ^ w_s[3];
    assign ovf    = r_ovf;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    cla4_slice u_slice (
        .a  (r_a_sh[3:0]),
        .b  (r_b_sh[3:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_run     = 1'b0;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_cnt == c_last) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy = w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef CLA_SERIAL_SUB_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh   <= {4'b0000, r_a_sh[WIDTH-1:4]};
            r_b_sh   <= {4'b0000, r_b_sh[WIDTH-1:4]};
            r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:4]};
            r_carry  <= w_co;
            r_cnt    <= r_cnt + CW'(1);
            // Result registers update only on the final nibble so they hold through IDLE.
            if (w_last) begin
                r_sum  <= {w_s, r_sum_sh[WIDTH-1:4]};
                r_cout <= w_co;
`ifdef CLA_SERIAL_SUB_EN
                r_ovf  <= w_c3 ^ w_co;
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_cla_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_cla_serial_add_ctrl
// Purpose  : Self-checking bench for cla_serial_add_ctrl (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_serial_add_ctrl;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef CLA_SERIAL_SUB_EN
    logic        sub;
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] sb_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        int          hold;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];
    int   n_vec;

    cla_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CLA_SERIAL_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_sub(input logic v);
`ifdef CLA_SERIAL_SUB_EN
        sub = v;
`else
        if (v) $display("note: subtract requested in an add-only build");
`endif
    endtask

    function automatic logic cur_sub();
`ifdef CLA_SERIAL_SUB_EN
        return sub;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                          input logic ci, input logic su);
        logic [15:0] be;
        logic        c;
        logic [16:0] r;
        be = su ? ~bb : bb;
        c  = su ? 1'b1 : ci;
        r  = {1'b0, aa} + {1'b0, be} + {16'd0, c};
        return {(aa[15] == be[15]) && (r[15] != aa[15]), r};
    endfunction

    task automatic sb_sample();
        logic [17:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sum", 32'(sum), 32'(e[15:0]));
                    check("sb_cout", 32'(cout), 32'(e[16]));
`ifdef CLA_SERIAL_SUB_EN
                    check("sb_ovf", 32'(ovf), 32'(e[17]));
`endif
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(a, b, cin, cur_sub()));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                         input logic si, input int hold, input logic chk,
                         input logic [15:0] es, input logic ec, input logic eo);
        int          edges;
        logic [15:0] s0;
        logic        c0;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        a = ai; b = bi; cin = ci; set_sub(si);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        edges = 1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); set_sub(1'($urandom));
        out_ready = (hold == 0);
        while (!out_valid && edges < 20) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_in_ready", 32'(in_ready), 32'd0);
            tick();
            edges++;
        end
        check("latency_edges", 32'(edges), 32'd5);
        s0 = sum; c0 = cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(s0));
            check("hold_cout", 32'(cout), 32'(c0));
        end
        in_valid = 1'b0;
        if (chk) begin
            check("vec_sum", 32'(sum), 32'(es));
            check("vec_cout", 32'(cout), 32'(ec));
`ifdef CLA_SERIAL_SUB_EN
            check("vec_ovf", 32'(ovf), 32'(eo));
`else
            if (eo) $display("note: overflow expectation ignored in add-only build");
`endif
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("idle_sum_hold", 32'(sum), 32'(s0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
    endtask

    initial begin
        int edges;
        n_vec = 0;
        vecs[n_vec++] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[n_vec++] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 3, 16'h5556, 1'b0, 1'b0};
        vecs[n_vec++] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
        vecs[n_vec++] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 1, 16'h0000, 1'b1, 1'b0};
        vecs[n_vec++] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 2, 16'hFFFF, 1'b0, 1'b0};
        vecs[n_vec++] = '{16'h8001, 16'h7FFF, 1'b1, 1'b0, 0, 16'h0001, 1'b1, 1'b0};
`ifdef CLA_SERIAL_SUB_EN
        vecs[n_vec++] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0};
        vecs[n_vec++] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1};
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
        tick(); tick();
        check_reset_vals("in_reset");
        rst = 1'b0;
        tick(); tick();
        check_reset_vals("idle");

        for (int i = 0; i < n_vec; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].hold, 1'b1,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Request held during RUN/DONE must wait for IDLE
        a = 16'h1000; b = 16'h2000; cin = 1'b0; set_sub(1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 16'h0001; b = 16'h0001;
        edges = 1;
        while (!out_valid && edges < 20) begin
            check("busy_req_in_ready", 32'(in_ready), 32'd0);
            tick();
            edges++;
        end
        check("busy_req_latency", 32'(edges), 32'd5);
        tick();
        check("busy_req_first_valid", 32'(out_valid), 32'd1);
        check("busy_req_first_sum", 32'(sum), 32'h3000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("busy_req_retry_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check("busy_req_second_latency", 32'(edges), 32'd5);
        check("busy_req_second_sum", 32'(sum), 32'h0002);
        check("busy_req_second_cout", 32'(cout), 32'd0);
        tick();
        out_ready = 1'b0;

        // Reset on the second RUN cycle
        a = 16'h8000; b = 16'h8000; cin = 1'b0; set_sub(1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        sb_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, i % 3, 1'b0,
                  16'h0000, 1'b0, 1'b0);
        end

        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
